// File: rtl/seg_pkg.sv
// Shared types for the seven-segment reader: pattern type, legal glyph codes and FSM states.
package seg_pkg;

    typedef logic [0:6] seg_t;

    // Active-low patterns, listed as seg[0:6] = a..g.
    localparam seg_t GLYPH_0   = 7'b0000001;
    localparam seg_t GLYPH_1   = 7'b1001111;
    localparam seg_t GLYPH_2   = 7'b0010010;
    localparam seg_t GLYPH_3   = 7'b0000110;
    localparam seg_t GLYPH_4   = 7'b1001100;
    localparam seg_t GLYPH_5   = 7'b0100100;
    localparam seg_t GLYPH_6   = 7'b0100000;
    localparam seg_t GLYPH_7   = 7'b0001111;
    localparam seg_t GLYPH_8   = 7'b0000000;
    localparam seg_t GLYPH_9   = 7'b0001100;
    localparam seg_t GLYPH_A   = 7'b0001000;
    localparam seg_t GLYPH_B   = 7'b1100000;
    localparam seg_t GLYPH_C   = 7'b0110001;
    localparam seg_t GLYPH_D   = 7'b1000010;
    localparam seg_t GLYPH_E   = 7'b0110000;
    localparam seg_t GLYPH_F   = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        REPORT,
        WAIT_CHANGE
    } state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational decode of one seven-segment pattern into a hex nibble plus blank/error flags.
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] data,
    output logic       blank,
    output logic       error
);

    // Anything that is neither a glyph nor all-off is flagged as an error with data 0.
    always_comb begin
        data  = 4'd0;
        blank = 1'b0;
        error = 1'b0;
        case (seg)
            GLYPH_0:   data = 4'h0;
            GLYPH_1:   data = 4'h1;
            GLYPH_2:   data = 4'h2;
            GLYPH_3:   data = 4'h3;
            GLYPH_4:   data = 4'h4;
            GLYPH_5:   data = 4'h5;
            GLYPH_6:   data = 4'h6;
            GLYPH_7:   data = 4'h7;
            GLYPH_8:   data = 4'h8;
            GLYPH_9:   data = 4'h9;
            GLYPH_A:   data = 4'hA;
            GLYPH_B:   data = 4'hB;
            GLYPH_C:   data = 4'hC;
            GLYPH_D:   data = 4'hD;
            GLYPH_E:   data = 4'hE;
            GLYPH_F:   data = 4'hF;
            SEG_BLANK: blank = 1'b1;
            default:   error = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Debounced seven-segment reader: reports each newly stable pattern once over a valid/ready handshake.
// Optional SEG_READER_ERRCNT_EN adds a saturating err_count output.
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [0:6] seg,
    input  logic       seg_en,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] data,
    output logic       blank,
    output logic       error
`ifdef SEG_READER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    seg_t          cand_q, cand_d;
    logic          valid_q, valid_d;
    logic [3:0]    data_q, data_d;
    logic          blank_q, blank_d;
    logic          error_q, error_d;

    logic [3:0]    dec_data;
    logic          dec_blank;
    logic          dec_error;

    seg_to_hex u_dec (
        .seg   (cand_q),
        .data  (dec_data),
        .blank (dec_blank),
        .error (dec_error)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= SEG_BLANK;
            valid_q <= 1'b0;
            data_q  <= 4'd0;
            blank_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            error_q <= error_d;
        end
    end

    // cand doubles as the last reported pattern while in REPORT and WAIT_CHANGE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        valid_d = valid_q;
        data_d  = data_q;
        blank_d = blank_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (seg_en) begin
                    cand_d  = seg;
                    cnt_d   = CNT_ONE;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!seg_en) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    data_d  = dec_data;
                    blank_d = dec_blank;
                    error_d = dec_error;
                    valid_d = 1'b1;
                    state_d = REPORT;
                end else if (seg != cand_q) begin
                    cand_d = seg;
                    cnt_d  = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REPORT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT_CHANGE;
                end
            end
            WAIT_CHANGE: begin
                if (!seg_en || (seg != cand_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SEG_READER_ERRCNT_EN
    // Counts accepted error reports, saturating at 255.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_count <= 8'd0;
        end else if ((state_q == REPORT) && valid_q && out_ready && error_q
                     && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    assign out_valid = valid_q;
    assign data      = data_q;
    assign blank     = blank_q;
    assign error     = error_q;

endmodule

// File: tb/tb_seg_reader.sv
// Directed self-checking bench for seg_reader with STABLE_CYCLES = 4.
module tb_seg_reader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [0:6] seg;
    logic       seg_en;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] data;
    logic       blank;
    logic       error;
`ifdef SEG_READER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int testCount = 0;
    int failCount = 0;

    logic [6:0] glyphTable [16];

    seg_reader #(.STABLE_CYCLES(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .seg       (seg),
        .seg_en    (seg_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data      (data),
        .blank     (blank),
        .error     (error)
`ifdef SEG_READER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] s, input logic en, input logic rdy);
        seg       = s;
        seg_en    = en;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitValid(input int maxCycles, input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < maxCycles; k++) begin
            tick();
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        int pulses;
        glyphTable[0]  = 7'b0000001; glyphTable[1]  = 7'b1001111;
        glyphTable[2]  = 7'b0010010; glyphTable[3]  = 7'b0000110;
        glyphTable[4]  = 7'b1001100; glyphTable[5]  = 7'b0100100;
        glyphTable[6]  = 7'b0100000; glyphTable[7]  = 7'b0001111;
        glyphTable[8]  = 7'b0000000; glyphTable[9]  = 7'b0001100;
        glyphTable[10] = 7'b0001000; glyphTable[11] = 7'b1100000;
        glyphTable[12] = 7'b0110001; glyphTable[13] = 7'b1000010;
        glyphTable[14] = 7'b0110000; glyphTable[15] = 7'b0111000;

        // Reset state
        Reset = 1'b1;
        applyStimulus(7'b0000000, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data",  {28'd0, data},      32'd0);
        checkOutput("rst_blank", {31'd0, blank},     32'd0);
        checkOutput("rst_error", {31'd0, error},     32'd0);
`ifdef SEG_READER_ERRCNT_EN
        checkOutput("rst_errcnt", {24'd0, err_count}, 32'd0);
`endif

        // Latency: glyph 2 stable, valid appears after edge 5, single pulse
        Reset = 1'b0;
        applyStimulus(7'b0010010, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("lat_edge%0d", k), {31'd0, out_valid}, 32'd0);
        end
        tick();
        checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("lat_data",  {28'd0, data},      32'd2);
        checkOutput("lat_blank", {31'd0, blank},     32'd0);
        checkOutput("lat_error", {31'd0, error},     32'd0);
        tick();
        checkOutput("lat_handshake", {31'd0, out_valid}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            pulses += int'(out_valid);
        end
        checkOutput("no_repeat", pulses, 32'd0);

        // Alternating 0/1 never settles, then 1 held reports data 1
        pulses = 0;
        for (int p = 0; p < 5; p++) begin
            applyStimulus(7'b0000001, 1'b1, 1'b1);
            tick(); pulses += int'(out_valid);
            tick(); pulses += int'(out_valid);
            applyStimulus(7'b1001111, 1'b1, 1'b1);
            tick(); pulses += int'(out_valid);
            tick(); pulses += int'(out_valid);
        end
        checkOutput("alt_no_valid", pulses, 32'd0);
        waitValid(8, "alt");
        checkOutput("alt_data", {28'd0, data}, 32'd1);
        tick();

        // Blank then illegal pattern
        applyStimulus(7'b1111111, 1'b1, 1'b1);
        waitValid(10, "blank");
        checkOutput("blank_flag",  {31'd0, blank}, 32'd1);
        checkOutput("blank_data",  {28'd0, data},  32'd0);
        checkOutput("blank_error", {31'd0, error}, 32'd0);
        tick();
        applyStimulus(7'b1111110, 1'b1, 1'b1);
        waitValid(10, "illegal");
        checkOutput("illegal_error", {31'd0, error}, 32'd1);
        checkOutput("illegal_data",  {28'd0, data},  32'd0);
        checkOutput("illegal_blank", {31'd0, blank}, 32'd0);
        tick();
`ifdef SEG_READER_ERRCNT_EN
        checkOutput("errcnt_one", {24'd0, err_count}, 32'd1);
`endif

        // Backpressure: A held while seg moves to F
        applyStimulus(7'b0001000, 1'b1, 1'b0);
        waitValid(10, "bp");
        checkOutput("bp_data", {28'd0, data}, 32'd10);
        applyStimulus(7'b0111000, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("bp_hold_valid%0d", k), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp_hold_data%0d", k),  {28'd0, data},      32'd10);
        end
        applyStimulus(7'b0111000, 1'b1, 1'b1);
        tick();
        checkOutput("bp_accept", {31'd0, out_valid}, 32'd0);
        waitValid(12, "bp_next");
        checkOutput("bp_next_data", {28'd0, data}, 32'd15);
        tick();

        // Reset during a pending report discards it
        applyStimulus(7'b1000010, 1'b1, 1'b0);
        waitValid(12, "rstrep");
        checkOutput("rstrep_data", {28'd0, data}, 32'd13);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        applyStimulus(7'b1000010, 1'b0, 1'b1);
        checkOutput("rstrep_valid_cleared", {31'd0, out_valid}, 32'd0);
        checkOutput("rstrep_data_cleared",  {28'd0, data},      32'd0);
`ifdef SEG_READER_ERRCNT_EN
        checkOutput("rstrep_errcnt", {24'd0, err_count}, 32'd0);
`endif
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            pulses += int'(out_valid);
        end
        checkOutput("rstrep_not_delivered", pulses, 32'd0);

        // Sweep all glyphs with handshakes
        for (int i = 0; i < 16; i++) begin
            applyStimulus(glyphTable[i], 1'b1, 1'b1);
            waitValid(12, $sformatf("sweep%0d", i));
            checkOutput($sformatf("sweep_data%0d", i),  {28'd0, data},  i);
            checkOutput($sformatf("sweep_error%0d", i), {31'd0, error}, 32'd0);
            checkOutput($sformatf("sweep_blank%0d", i), {31'd0, blank}, 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
